des_sbox_pipe: RTL and testbench

//  Parametrised DES substitution stage for the round function. Maps 6*NUM_BOXES

---
 rtl/des_sbox_pipe_if.sv | 23 ++
 rtl/des_sbox_pipe.sv | 175 +++++++++++++++++
 tb/tb_des_sbox_pipe.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/des_sbox_pipe_if.sv
// Handshake bundle for the DES S-box stage: input word channel,
// output word channel and occupancy flag.
interface des_sbox_pipe_if #(
    parameter int NUM_BOXES = 8
);
    logic                     In_Valid;
    logic                     In_Ready;
    logic [6*NUM_BOXES-1:0]   In_Data;
    logic                     Out_Valid;
    logic                     Out_Ready;
    logic [4*NUM_BOXES-1:0]   Out_Data;
    logic                     Busy;

    modport master (
        output In_Valid, In_Data, Out_Ready,
        input  In_Ready, Out_Valid, Out_Data, Busy
    );

    modport slave (
        input  In_Valid, In_Data, Out_Ready,
        output In_Ready, Out_Valid, Out_Data, Busy
    );
endinterface

// File: rtl/des_sbox_pipe.sv
// DES S-box substitution stage: parallel pipelined lookup of all boxes,
// or a serial build sharing one lookup across boxes.
module des_sbox_pipe #(
    parameter int NUM_BOXES   = 8,
    parameter int FIRST_BOX   = 1,
    parameter int PIPE_STAGES = 1,
    parameter int SERIAL      = 0
) (
    input logic            Clk,
    input logic            Rst_n,
    des_sbox_pipe_if.slave bus
);
    localparam int NB = NUM_BOXES;
    localparam int IW = 6 * NB;
    localparam int DW = 4 * NB;

    // Each box: rows 0..3, 16 nibbles per row, row 0 column 0 in the MS nibble.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    function automatic logic [3:0] sbox(input logic [2:0] b, input logic [5:0] x);
        logic [5:0] idx;
        idx = {x[5], x[0], x[4:1]};
        return SBOX[b][8'd255 - {idx, 2'b00} -: 4];
    endfunction

    if (SERIAL == 0) begin : g_par
        localparam int PS = PIPE_STAGES;

        logic [DW-1:0] look;
        logic [DW-1:0] dat_q [PS];
        logic [DW-1:0] dat_d [PS];
        logic [PS-1:0] vld_q;
        logic [PS-1:0] vld_d;
        logic          stall;

        always_comb begin
            look = '0;
            for (int i = 0; i < NB; i++) begin
                look[DW-1-4*i -: 4] = sbox(3'(FIRST_BOX - 1 + i),
                                           bus.In_Data[IW-1-6*i -: 6]);
            end
        end

        // The whole pipe freezes on an output stall; bubbles move like words.
        always_comb begin
            stall = vld_q[PS-1] & ~bus.Out_Ready;
            vld_d = vld_q;
            dat_d = dat_q;
            if (!stall) begin
                vld_d[0] = bus.In_Valid;
                if (bus.In_Valid) dat_d[0] = look;
                for (int s = 1; s < PS; s++) begin
                    vld_d[s] = vld_q[s-1];
                    if (vld_q[s-1]) dat_d[s] = dat_q[s-1];
                end
            end
        end

        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                vld_q <= '0;
                for (int s = 0; s < PS; s++) dat_q[s] <= '0;
            end else begin
                vld_q <= vld_d;
                dat_q <= dat_d;
            end
        end

        assign bus.In_Ready  = ~stall;
        assign bus.Out_Valid = vld_q[PS-1];
        assign bus.Out_Data  = dat_q[PS-1];
        assign bus.Busy      = |vld_q;
    end else begin : g_ser
        localparam int CW = (NB > 1) ? $clog2(NB) : 1;

        typedef enum logic [1:0] {
            S_IDLE = 2'd0,
            S_RUN  = 2'd1,
            S_DONE = 2'd2
        } st_e;

        st_e           st_q, st_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [IW-1:0] in_q, in_d;
        logic [DW-1:0] sh_q, sh_d;
        logic [DW-1:0] out_q, out_d;
        logic          vld_q, vld_d;
        logic          rdy_q, rdy_d;
        logic [2:0]    bidx;
        logic [3:0]    nib;

        assign bidx = 3'(FIRST_BOX - 1 + int'(cnt_q));
        assign nib  = sbox(bidx, in_q[IW-1 -: 6]);

        // Input word shifts left so the current box always sits in the MS group.
        always_comb begin
            st_d  = st_q;
            cnt_d = cnt_q;
            in_d  = in_q;
            sh_d  = sh_q;
            out_d = out_q;
            vld_d = vld_q;
            rdy_d = rdy_q;
            case (st_q)
                S_IDLE: begin
                    if (bus.In_Valid) begin
                        in_d  = bus.In_Data;
                        cnt_d = '0;
                        rdy_d = 1'b0;
                        st_d  = S_RUN;
                    end
                end
                S_RUN: begin
                    sh_d = (sh_q << 4) | DW'(nib);
                    in_d = in_q << 6;
                    if (cnt_q == CW'(NB - 1)) begin
                        cnt_d = '0;
                        out_d = sh_d;
                        vld_d = 1'b1;
                        st_d  = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.Out_Ready) begin
                        vld_d = 1'b0;
                        rdy_d = 1'b1;
                        st_d  = S_IDLE;
                    end
                end
                default: begin
                    cnt_d = '0;
                    vld_d = 1'b0;
                    rdy_d = 1'b1;
                    st_d  = S_IDLE;
                end
            endcase
        end

        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                st_q  <= S_IDLE;
                cnt_q <= '0;
                in_q  <= '0;
                sh_q  <= '0;
                out_q <= '0;
                vld_q <= 1'b0;
                rdy_q <= 1'b1;
            end else begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
                in_q  <= in_d;
                sh_q  <= sh_d;
                out_q <= out_d;
                vld_q <= vld_d;
                rdy_q <= rdy_d;
            end
        end

        assign bus.In_Ready  = rdy_q;
        assign bus.Out_Valid = vld_q;
        assign bus.Out_Data  = out_q;
        assign bus.Busy      = (st_q != S_IDLE);
    end
endmodule

// File: tb/tb_des_sbox_pipe.sv
// Directed bench for des_sbox_pipe: parallel, deep-pipe, single-box and
// serial builds side by side, sharing clock and reset.
module tb_des_sbox_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    des_sbox_pipe_if #(.NUM_BOXES(8)) m1 ();
    des_sbox_pipe_if #(.NUM_BOXES(8)) m3 ();
    des_sbox_pipe_if #(.NUM_BOXES(1)) ma ();
    des_sbox_pipe_if #(.NUM_BOXES(1)) mb ();
    des_sbox_pipe_if #(.NUM_BOXES(8)) ms ();

    des_sbox_pipe #(.NUM_BOXES(8), .FIRST_BOX(1), .PIPE_STAGES(1), .SERIAL(0))
        u_p1 (.Clk(clk), .Rst_n(rst_n), .bus(m1));
    des_sbox_pipe #(.NUM_BOXES(8), .FIRST_BOX(1), .PIPE_STAGES(3), .SERIAL(0))
        u_p3 (.Clk(clk), .Rst_n(rst_n), .bus(m3));
    des_sbox_pipe #(.NUM_BOXES(1), .FIRST_BOX(1), .PIPE_STAGES(1), .SERIAL(0))
        u_ba (.Clk(clk), .Rst_n(rst_n), .bus(ma));
    des_sbox_pipe #(.NUM_BOXES(1), .FIRST_BOX(2), .PIPE_STAGES(1), .SERIAL(0))
        u_bb (.Clk(clk), .Rst_n(rst_n), .bus(mb));
    des_sbox_pipe #(.NUM_BOXES(8), .FIRST_BOX(1), .PIPE_STAGES(1), .SERIAL(1))
        u_s (.Clk(clk), .Rst_n(rst_n), .bus(ms));

    typedef struct {
        logic [47:0] din;
        logic [31:0] dout;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sent, rcv, lat, l3, ls;
        logic held_v;
        logic [31:0] held, d3, ds;

        vt[0] = '{48'h6117BA866527, 32'h5C82B597};
        vt[1] = '{48'h000000000000, 32'hEFA72C4D};
        vt[2] = '{48'hFFFFFFFFFFFF, 32'hD9CE3DCB};
        vt[3] = '{48'h041041041041, 32'h03DDEAD1};
        vt[4] = '{48'h820820820820, 32'h40DA4917};
        vt[5] = '{48'h79E79E79E79E, 32'h7A8F9B17};
        vt[6] = '{48'h861861861861, 32'hFD13B462};
        vt[7] = '{48'h00210620A30E, 32'hE1937281};

        m1.In_Valid = 0; m1.In_Data = '0; m1.Out_Ready = 1;
        m3.In_Valid = 0; m3.In_Data = '0; m3.Out_Ready = 1;
        ma.In_Valid = 0; ma.In_Data = '0; ma.Out_Ready = 1;
        mb.In_Valid = 0; mb.In_Data = '0; mb.Out_Ready = 1;
        ms.In_Valid = 0; ms.In_Data = '0; ms.Out_Ready = 1;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst p1 in_ready", m1.In_Ready, 1);
        chk("rst p1 out_valid", m1.Out_Valid, 0);
        chk("rst p1 out_data", m1.Out_Data, 0);
        chk("rst p1 busy", m1.Busy, 0);
        chk("rst s in_ready", ms.In_Ready, 1);
        chk("rst s busy", ms.Busy, 0);
        chk("rst s out_data", ms.Out_Data, 0);

        // back-to-back table through the single-stage pipe
        for (int i = 0; i < 8; i++) begin
            m1.In_Valid = 1;
            m1.In_Data  = vt[i].din;
            step();
            chk($sformatf("p1 vec%0d valid", i), m1.Out_Valid, 1);
            chk($sformatf("p1 vec%0d data", i), m1.Out_Data, vt[i].dout);
        end
        m1.In_Valid = 0;
        step();
        chk("p1 drain valid", m1.Out_Valid, 0);
        chk("p1 retain data", m1.Out_Data, vt[7].dout);
        chk("p1 drain busy", m1.Busy, 0);

        // single-box builds, first box S1 and S2
        ma.In_Valid = 1; ma.In_Data = 6'b011011;
        mb.In_Valid = 1; mb.In_Data = 6'b011011;
        step();
        chk("b1 S1 011011", ma.Out_Data, 4'd5);
        chk("b2 S2 011011", mb.Out_Data, 4'd9);
        ma.In_Data = 6'b100000;
        mb.In_Data = 6'b100000;
        step();
        chk("b1 S1 100000", ma.Out_Data, 4'd4);
        chk("b2 S2 100000", mb.Out_Data, 4'd0);
        ma.In_Valid = 0;
        mb.In_Valid = 0;

        // 10-word burst, sink stalls for cycles 5..8
        sent = 0; rcv = 0; held_v = 0; held = '0;
        for (int c = 0; c < 40 && rcv < 10; c++) begin
            if (held_v) begin
                chk("p3 hold valid", m3.Out_Valid, 1);
                chk("p3 hold data", m3.Out_Data, held);
            end
            m3.Out_Ready = !(c >= 5 && c < 9);
            m3.In_Valid  = (sent < 10);
            m3.In_Data   = vt[sent % 8].din;
            #1;
            chk($sformatf("p3 in_ready c%0d", c), m3.In_Ready, !(c >= 5 && c < 9));
            if (m3.Out_Valid && m3.Out_Ready) begin
                chk($sformatf("p3 word%0d", rcv), m3.Out_Data, vt[rcv % 8].dout);
                rcv++;
            end
            held_v = m3.Out_Valid && !m3.Out_Ready;
            held   = m3.Out_Data;
            if (m3.In_Valid && m3.In_Ready) sent++;
            step();
        end
        m3.In_Valid = 0;
        m3.Out_Ready = 1;
        chk("p3 words received", 64'(rcv), 64'd10);
        chk("p3 words sent", 64'(sent), 64'd10);

        // serial build, sink ready
        chk("s idle in_ready", ms.In_Ready, 1);
        ms.In_Valid = 1; ms.In_Data = vt[0].din; ms.Out_Ready = 1;
        step();
        ms.In_Valid = 0;
        lat = 1;
        while (!ms.Out_Valid && lat < 30) begin
            chk($sformatf("s in_ready low l%0d", lat), ms.In_Ready, 0);
            chk($sformatf("s busy l%0d", lat), ms.Busy, 1);
            step();
            lat++;
        end
        chk("s latency", 64'(lat), 64'd9);
        chk("s data", ms.Out_Data, vt[0].dout);
        chk("s in_ready done", ms.In_Ready, 0);
        step();
        chk("s in_ready after take", ms.In_Ready, 1);
        chk("s valid after take", ms.Out_Valid, 0);
        chk("s busy after take", ms.Busy, 0);
        chk("s retain data", ms.Out_Data, vt[0].dout);

        // serial build, sink holds off two cycles in DONE
        ms.In_Valid = 1; ms.In_Data = vt[1].din; ms.Out_Ready = 0;
        step();
        ms.In_Valid = 0;
        repeat (8) step();
        chk("s2 valid", ms.Out_Valid, 1);
        chk("s2 data", ms.Out_Data, vt[1].dout);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("s2 hold valid", ms.Out_Valid, 1);
            chk("s2 hold data", ms.Out_Data, vt[1].dout);
            chk("s2 hold in_ready", ms.In_Ready, 0);
        end
        ms.Out_Ready = 1;
        step();
        chk("s2 valid after take", ms.Out_Valid, 0);
        chk("s2 in_ready after take", ms.In_Ready, 1);

        // reset mid-flight: serial in RUN, deep pipe full and stalled
        ms.In_Valid = 1; ms.In_Data = vt[3].din;
        m3.Out_Ready = 0; m3.In_Valid = 1; m3.In_Data = vt[4].din;
        step();
        ms.In_Valid = 0;
        repeat (3) step();
        chk("pre-rst p3 valid", m3.Out_Valid, 1);
        chk("pre-rst p3 in_ready", m3.In_Ready, 0);
        chk("pre-rst s busy", ms.Busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst p3 valid", m3.Out_Valid, 0);
        chk("rst p3 busy", m3.Busy, 0);
        chk("rst p3 data", m3.Out_Data, 0);
        chk("rst p3 in_ready", m3.In_Ready, 1);
        chk("rst s valid", ms.Out_Valid, 0);
        chk("rst s busy", ms.Busy, 0);
        chk("rst s in_ready", ms.In_Ready, 1);
        m3.In_Valid = 0;
        m3.Out_Ready = 1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("post-rst p3 quiet", m3.Out_Valid, 0);
            chk("post-rst s quiet", ms.Out_Valid, 0);
        end

        m3.In_Valid = 1; m3.In_Data = vt[5].din;
        ms.In_Valid = 1; ms.In_Data = vt[5].din;
        l3 = 0; ls = 0; d3 = '0; ds = '0;
        for (int n = 1; n <= 14; n++) begin
            step();
            m3.In_Valid = 0;
            ms.In_Valid = 0;
            if (m3.Out_Valid && l3 == 0) begin l3 = n; d3 = m3.Out_Data; end
            if (ms.Out_Valid && ls == 0) begin ls = n; ds = ms.Out_Data; end
        end
        chk("post-rst p3 latency", 64'(l3), 64'd3);
        chk("post-rst p3 data", d3, vt[5].dout);
        chk("post-rst s latency", 64'(ls), 64'd9);
        chk("post-rst s data", ds, vt[5].dout);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
